flag_unit: RTL

//  Producer side of the condition-flag interface consumed by branch PC selection.

---
 rtl/flag_unit.sv | 87 ++++++++
 1 files changed

// File: rtl/flag_unit.sv
// flag_unit: condition-flag producer for branch PC selection.
// Captures {V,N,Z} from the EX-stage ALU result according to opcode class.
// Holds them in an architectural flag register and feeds F to ID.
// A branch/flag hazard is resolved either by forwarding the EX flags or by
// a single-cycle ID stall, chosen by FORWARD.
module flag_unit #(
    parameter bit         FORWARD   = 1'b1,
    parameter logic [2:0] RST_FLAGS = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] alu_result,
    input  logic        alu_ovfl,
    input  logic        id_cond_br,
    output logic [2:0]  F,
    output logic [2:0]  flag_reg,
    output logic        flag_stall
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    logic [2:0] flag_reg_q, flag_reg_d;
    logic       set_full, set_z;
    logic       upd;
    logic [2:0] flags_nxt;

    // Decode opcode class and merge fresh flags with the retained ones.
    always_comb begin
        set_full  = 1'b0;
        set_z     = 1'b0;
        flags_nxt = flag_reg_q;
        case (ex_opcode)
            OP_ADD, OP_SUB:                 set_full = 1'b1;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: set_z    = 1'b1;
            default: ;
        endcase
        if (set_full) begin
            flags_nxt = {alu_ovfl, alu_result[15], (alu_result == 16'h0000)};
        end else if (set_z) begin
            flags_nxt[0] = (alu_result == 16'h0000);
        end
        // A squashed op writes nothing, even if it belongs to a setting class.
        upd = ex_valid & ~ex_flush & (set_full | set_z);
    end

    // Register write qualified by the pipeline advance.
    always_comb begin
        flag_reg_d = flag_reg_q;
        if (upd && en) begin
            flag_reg_d = flags_nxt;
        end
    end

    // Architectural flag register; reset also drops any in-flight update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_reg_q <= RST_FLAGS;
        end else begin
            flag_reg_q <= flag_reg_d;
        end
    end

    // Branch-facing flags and hazard stall; stall is independent of en.
    always_comb begin
        F          = flag_reg_q;
        flag_stall = 1'b0;
        if (FORWARD) begin
            if (upd) begin
                F = flags_nxt;
            end
        end else begin
            flag_stall = id_cond_br & upd;
        end
    end

    assign flag_reg = flag_reg_q;

endmodule
